cpu4_instr_issuer: RTL and testbench

//  Host-side driver for the 4-bit accumulator CPU: buffers 12-bit instruction words from a

---
 rtl/cpu4_instr_issuer_pkg.sv | 42 ++++
 rtl/cpu4_instr_issuer_if.sv | 37 +++
 rtl/cpu4_instr_issuer_sync_fifo.sv | 54 +++++
 rtl/cpu4_instr_issuer.sv | 132 +++++++++++++
 tb/tb_cpu4_instr_issuer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu4_instr_issuer_pkg.sv
// Shared definitions for the 4-bit CPU instruction issuer.
// Contents: instruction word width, opcode encodings, instruction field layout,
// issuer FSM state encoding and the illegal-opcode decode helper.
package cpu4_instr_issuer_pkg;

  localparam int INSTR_W = 12;

  // Opcodes understood by the accumulator CPU. 4'h4 is accepted and passed
  // through unchanged. Only 4'hA..4'hE are treated as illegal.
  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_STORE = 4'h2,
    OP_LOAD  = 4'h3,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_NOP   = 4'hF
  } opcode_e;

  // Instruction word layout {opcode[11:8], addr[7:4], data[3:0]}.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] addr;
    logic [3:0] data;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/cpu4_instr_issuer_if.sv
// Signal bundle between the host, the issuer and the CPU core.
// Groups: host instruction stream (run, in_valid/in_ready/in_instr), CPU pins
// (cpu_opcode/addr/data/we, cpu_result), result stream (out_valid/out_ready/
// out_result) and status (busy, issued_cnt, illegal_err).
// Modports: master = host/CPU environment side, slave = the issuer.
interface cpu4_instr_issuer_if;
  import cpu4_instr_issuer_pkg::*;

  logic               run;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [3:0]         cpu_opcode;
  logic [3:0]         cpu_addr;
  logic [3:0]         cpu_data;
  logic               cpu_we;
  logic [3:0]         cpu_result;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_result;
  logic               busy;
  logic [7:0]         issued_cnt;
  logic               illegal_err;

  modport master (
    output run, in_valid, in_instr, cpu_result, out_ready,
    input  in_ready, cpu_opcode, cpu_addr, cpu_data, cpu_we,
           out_valid, out_result, busy, issued_cnt, illegal_err
  );

  modport slave (
    input  run, in_valid, in_instr, cpu_result, out_ready,
    output in_ready, cpu_opcode, cpu_addr, cpu_data, cpu_we,
           out_valid, out_result, busy, issued_cnt, illegal_err
  );

endinterface

// File: rtl/cpu4_instr_issuer_sync_fifo.sv
// Single-clock FIFO buffering host instruction words.
// Ports: clk, rst (async, active-high), push_i/wdata_i (write, ignored when
// full), pop_i (read, ignored when empty), rdata_o (head word, valid when
// !empty_o), full_o, empty_o.
// Pointers carry one extra wrap bit so full and empty are distinguished by the
// MSB compare alone.
module cpu4_instr_issuer_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values; reset is asynchronous and listed in the sensitivity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cpu4_instr_issuer.sv
// Host-side driver for the 4-bit accumulator CPU.
// Ports: clk, rst (async, active-high), bus (slave modport of
// cpu4_instr_issuer_if, see that file for the signal list).
// Pops one buffered instruction at a time while run=1, drives it on the CPU
// pins for EXEC_LAT cycles, then captures {opcode, accumulator} into the
// result stream and waits for the host to take it. Illegal opcodes
// (4'hA..4'hE) are discarded and flagged in the sticky illegal_err.
module cpu4_instr_issuer
  import cpu4_instr_issuer_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         EXEC_LAT = 3,
  parameter logic [3:0] NOP_OP   = 4'hF
) (
  input logic                clk,
  input logic                rst,
  cpu4_instr_issuer_if.slave bus
);

  // Hold counter only ever holds EXEC_LAT-1.
  localparam int     CNT_W    = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
  localparam instr_t NOP_PINS = '{opcode: NOP_OP, addr: 4'h0, data: 4'h0};

  state_e             state_q;
  logic [CNT_W-1:0]   hold_q;
  instr_t             pins_q;
  logic               we_q;
  logic [3:0]         cur_op_q;
  logic               out_valid_q;
  logic [7:0]         out_result_q;
  logic [7:0]         issued_q;
  logic               illegal_q;

  logic [INSTR_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  instr_t             head;

  assign head = instr_t'(fifo_rdata);
  assign pop  = (state_q == ST_IDLE) && bus.run && !fifo_empty;

  cpu4_instr_issuer_sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .wdata_i (bus.in_instr),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      pins_q       <= NOP_PINS;
      we_q         <= 1'b0;
      cur_op_q     <= NOP_OP;
      out_valid_q  <= 1'b0;
      out_result_q <= 8'h00;
      issued_q     <= 8'h00;
      illegal_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            if (is_illegal(head.opcode)) begin
              // Discarded: no pins, no result, no count.
              illegal_q <= 1'b1;
            end else begin
              // Pins are loaded at the pop edge so they are already visible
              // during ISSUE; ISSUE + HOLD together span EXEC_LAT cycles.
              pins_q   <= head;
              we_q     <= (head.opcode == OP_STORE);
              cur_op_q <= head.opcode;
              state_q  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          hold_q <= CNT_W'(EXEC_LAT - 1);
          if (EXEC_LAT == 1) begin
            pins_q  <= NOP_PINS;
            we_q    <= 1'b0;
            state_q <= ST_CAPTURE;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          hold_q <= hold_q - 1'b1;
          if (hold_q == CNT_W'(1)) begin
            pins_q  <= NOP_PINS;
            we_q    <= 1'b0;
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // CPU is idle on NOP here, so the accumulator is stable.
          out_result_q <= {cur_op_q, bus.cpu_result};
          out_valid_q  <= 1'b1;
          issued_q     <= issued_q + 8'd1;
          state_q      <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.cpu_opcode  = pins_q.opcode;
  assign bus.cpu_addr    = pins_q.addr;
  assign bus.cpu_data    = pins_q.data;
  assign bus.cpu_we      = we_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.issued_cnt  = issued_q;
  assign bus.illegal_err = illegal_q;

endmodule

// File: tb/tb_cpu4_instr_issuer.sv
// Self-checking bench for cpu4_instr_issuer (DEPTH=8, EXEC_LAT=3).
// Stimulus is driven 1 time unit after the rising edge; monitors sample on the
// falling edge. A tiny CPU stand-in makes the accumulator equal to
// (addr ^ data) + number of cycles the instruction was seen on the pins, so a
// result word also proves the hold length.
module tb_cpu4_instr_issuer;

  localparam int DEPTH    = 8;
  localparam int EXEC_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu4_instr_issuer_if bus();

  cpu4_instr_issuer #(
    .DEPTH    (DEPTH),
    .EXEC_LAT (EXEC_LAT),
    .NOP_OP   (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_res = 0;
  int         n_legal = 0;
  bit         exp_illegal = 1'b0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    n_cmp++;
    assert (cond) else begin
      n_err++;
      $error("FAIL %s: observed 0 expected 1", tag);
    end
  endtask

  // CPU stand-in: counts consecutive cycles with a non-NOP opcode on the pins.
  logic [3:0] acc = 4'h0;
  int         run_len = 0;
  always @(negedge clk) begin
    if (rst || bus.cpu_opcode == 4'hF) begin
      run_len <= 0;
    end else begin
      run_len <= run_len + 1;
      acc     <= (bus.cpu_addr ^ bus.cpu_data) + 4'(run_len + 1);
    end
  end
  assign bus.cpu_result = acc;

  // Scoreboard and output-hold monitor.
  logic       pv_valid = 1'b0;
  logic       pv_ready = 1'b0;
  logic [7:0] pv_res = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      pv_valid <= 1'b0;
    end else begin
      check_true("we_only_store", bus.cpu_we === (bus.cpu_opcode == 4'h2));
      if (pv_valid && !pv_ready)
        check_true("out_hold", bus.out_valid === 1'b1 && bus.out_result === pv_res);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check_true("extra_result", 1'b0);
        else check("out_result", bus.out_result, exp_q.pop_front());
        n_res++;
      end
      pv_valid <= bus.out_valid;
      pv_ready <= bus.out_ready;
      pv_res   <= bus.out_result;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] rand_instr(input bit allow_illegal);
    logic [3:0] op;
    op = allow_illegal ? 4'($urandom_range(0, 14)) : 4'($urandom_range(0, 9));
    return {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
  endfunction

  // Model update for an accepted word: legal ones yield a result in order.
  task automatic note_push(input logic [11:0] w);
    logic [3:0] op;
    logic [3:0] r;
    op = w[11:8];
    if (op >= 4'hA && op <= 4'hE) begin
      exp_illegal = 1'b1;
    end else begin
      r = (w[7:4] ^ w[3:0]) + 4'(EXEC_LAT);
      exp_q.push_back({op, r});
      n_legal++;
    end
  endtask

  task automatic push(input logic [11:0] w, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    ok = bus.in_ready;
    if (ok) note_push(w);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [11:0] w);
    bit ok;
    int k;
    for (k = 0; k < 500 && !bus.in_ready; k++) begin
      if (k > 20) begin
        bus.run       = 1'b1;
        bus.out_ready = 1'b1;
      end
      tick();
    end
    check_true("push_timeout", k < 500);
    push(w, ok);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget && (bus.busy || bus.out_valid); k++) tick();
    check_true("drain_timeout", k < budget);
    check("scoreboard_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_opcode", bus.cpu_opcode, 4'hF);
    check("rst_addr", bus.cpu_addr, 0);
    check("rst_data", bus.cpu_data, 0);
    check("rst_we", bus.cpu_we, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_issued", bus.issued_cnt, 0);
    check("rst_illegal", bus.illegal_err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
  endtask

  initial begin
    bit ok;
    int hits;
    int first;
    int base;
    logic [7:0] held;

    bus.run       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 12'h000;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check_reset_values();
    rst = 1'b0;
    tick();

    // 1: LOAD addr5 -- pin window length and pop-to-valid latency.
    bus.run = 1'b1;
    push(12'h350, ok);
    hits  = 0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.cpu_opcode == 4'h3 && bus.cpu_addr == 4'h5 && bus.cpu_data == 4'h0) hits++;
      if (bus.out_valid && first == 0) first = k;
    end
    check("load_pin_cycles", hits, EXEC_LAT);
    check("load_valid_cycle", first, EXEC_LAT + 2);
    wait_idle(50);
    check("load_issued", bus.issued_cnt, 1);

    // 2: STORE -- write enable exactly over the pin window.
    push(12'h270, ok);
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.cpu_we) hits++;
    end
    check("store_we_cycles", hits, EXEC_LAT);
    wait_idle(50);

    // 3: fill with run=0, ninth push dropped, then drain in order.
    bus.run = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      push(rand_instr(1'b0), ok);
      check("fill_accept", ok, 1);
      check("fill_in_ready", bus.in_ready, i < DEPTH);
    end
    push(12'h0FF, ok);
    check("full_push_dropped", ok, 0);
    check("full_busy", bus.busy, 1);
    base = n_res;
    bus.run = 1'b1;
    wait_idle(DEPTH * (EXEC_LAT + 3) + 20);
    check("fill_result_count", n_res - base, DEPTH);

    // 4: result back-pressure holds the result and blocks further pops.
    bus.out_ready = 1'b0;
    push(rand_instr(1'b0), ok);
    push(rand_instr(1'b0), ok);
    for (int k = 0; k < 50 && !bus.out_valid; k++) tick();
    check("bp_valid_seen", bus.out_valid, 1);
    held = bus.out_result;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_stable", {bus.out_valid, bus.out_result, bus.cpu_opcode, bus.busy},
            {1'b1, held, 4'hF, 1'b1});
    end
    bus.out_ready = 1'b1;
    wait_idle(50);

    // 5: illegal opcode discarded, flagged, only the ADD yields a result.
    base = n_res;
    push(12'hC12, ok);
    push(12'h034, ok);
    wait_idle(50);
    check("illegal_flag", bus.illegal_err, 1);
    check("illegal_results", n_res - base, 1);
    check("illegal_issued", bus.issued_cnt, 8'(n_legal));

    // Randomized traffic with run and out_ready toggling.
    for (int i = 0; i < 60; i++) begin
      bus.run       = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      push_wait(rand_instr(1'b1));
      repeat ($urandom_range(0, 4)) tick();
    end
    bus.run       = 1'b1;
    bus.out_ready = 1'b1;
    wait_idle(600);
    check("rand_issued", bus.issued_cnt, 8'(n_legal));
    check("rand_illegal", bus.illegal_err, exp_illegal);

    // 6: reset during HOLD with a second word queued.
    push(12'h412, ok);
    push(12'h156, ok);
    for (int k = 0; k < 20 && bus.cpu_opcode == 4'hF; k++) tick();
    tick();
    check("pre_rst_pins", bus.cpu_opcode, 4'h4);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    exp_q.delete();
    n_legal     = 0;
    exp_illegal = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 255; i++) push_wait(rand_instr(1'b0));
    wait_idle(200);
    check("cnt_255", bus.issued_cnt, 8'd255);
    push_wait(rand_instr(1'b0));
    wait_idle(50);
    check("cnt_wrap", bus.issued_cnt, 8'(n_legal));
    check("cnt_wrap_zero", bus.issued_cnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
